// File: rtl/ascon_if_pkg.sv
// rtl/ascon_if_pkg.sv - shared widths, lane-max helper and FSM states for the ASCON serial interface
package ascon_if_pkg;

  localparam int DEF_KEY_W   = 128;
  localparam int DEF_NONCE_W = 128;
  localparam int DEF_AD_W    = 40;
  localparam int DEF_DATA_W  = 104;
  localparam int DEF_TAG_W   = 128;
  localparam int DEF_PRE_CYC = 2;

  typedef enum logic [1:0] {LOAD, BUSY, UNLOAD, DONE} state_t;

  function automatic int lane_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ascon_serial_if_if.sv
// rtl/ascon_serial_if_if.sv - parallel lanes and start/done handshake between serial interface and ASCON core
interface ascon_serial_if_if
  import ascon_if_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int AD_W    = DEF_AD_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = DEF_TAG_W
) ();

  logic [KEY_W-1:0]   key_o;
  logic [NONCE_W-1:0] nonce_o;
  logic [AD_W-1:0]    ad_o;
  logic [DATA_W-1:0]  data_o;
  logic               decrypt_o;
  logic               core_start_o;
  logic               core_done_i;
  logic [DATA_W-1:0]  core_data_i;
  logic [TAG_W-1:0]   core_tag_i;

  modport master (
    output key_o, nonce_o, ad_o, data_o, decrypt_o, core_start_o,
    input  core_done_i, core_data_i, core_tag_i
  );

  modport slave (
    input  key_o, nonce_o, ad_o, data_o, decrypt_o, core_start_o,
    output core_done_i, core_data_i, core_tag_i
  );

endinterface

// File: rtl/ascon_sipo_lane.sv
// rtl/ascon_sipo_lane.sv - MSB-first serial-in lane; bits beyond W are dropped
module ascon_sipo_lane #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic [CNT_W-1:0] count,
  input  logic             din,
  output logic [W-1:0]     q
);

  localparam logic [CNT_W-1:0] W_C = CNT_W'(W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift && (count < W_C)) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/ascon_serial_if.sv
// rtl/ascon_serial_if.sv - pad-side bit-serial load/unload around the ASCON core
// Optional cycles_o busy-cycle counter under ASCON_CYCLE_CNT_EN.
module ascon_serial_if
  import ascon_if_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int AD_W    = DEF_AD_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int PRE_CYC = DEF_PRE_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rst,
  input  logic        keyxSI,
  input  logic        noncexSI,
  input  logic        associated_dataxSI,
  input  logic        input_dataxSI,
  input  logic        ascon_startxSI,
  input  logic        decrypt,
  output logic        output_dataxSO,
  output logic        tagxSO,
  output logic        ascon_readyxSO,
  output logic        load_err_o,
`ifdef ASCON_CYCLE_CNT_EN
  output logic [15:0] cycles_o,
`endif
  ascon_serial_if_if.master core
);

  localparam int MAX_W = lane_max(KEY_W, NONCE_W, AD_W, DATA_W);
  localparam int OUT_W = (DATA_W > TAG_W) ? DATA_W : TAG_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int IDX_W = $clog2(OUT_W + 1);
  localparam int PRE_W = $clog2(PRE_CYC + 2);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic               start_q;
  logic               core_start_q;
  logic               decrypt_q;
  logic               load_err_q;
  logic               ready_q;
  logic [PRE_W-1:0]   pre_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  data_sr;
  logic [TAG_W-1:0]   tag_sr;
  logic [KEY_W-1:0]   key_lane;
  logic [NONCE_W-1:0] nonce_lane;
  logic [AD_W-1:0]    ad_lane;
  logic [DATA_W-1:0]  data_lane;

  logic start_edge, load_shift, full, go, capture, shift_out, last_bit;

  assign start_edge = ascon_startxSI & ~start_q;
  assign load_shift = (state_q == LOAD) & ~ascon_startxSI;
  assign full       = (count_q == CNT_W'(MAX_W));
  assign go         = (state_q == LOAD) & start_edge & full;
  assign capture    = (state_q == BUSY) & core.core_done_i;
  // Output index only advances once ready has been up for PRE_CYC cycles.
  assign shift_out  = (state_q == UNLOAD) & (pre_q == PRE_W'(PRE_CYC));
  assign last_bit   = shift_out & (idx_q == IDX_W'(OUT_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (go) state_d = BUSY;
        BUSY:    if (core.core_done_i) state_d = UNLOAD;
        UNLOAD:  if (last_bit) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      start_q      <= 1'b0;
      core_start_q <= 1'b0;
      decrypt_q    <= 1'b0;
      load_err_q   <= 1'b0;
      ready_q      <= 1'b0;
      pre_q        <= '0;
      idx_q        <= '0;
      data_sr      <= '0;
      tag_sr       <= '0;
    end else if (rst) begin
      count_q      <= '0;
      start_q      <= 1'b0;
      core_start_q <= 1'b0;
      decrypt_q    <= 1'b0;
      load_err_q   <= 1'b0;
      ready_q      <= 1'b0;
      pre_q        <= '0;
      idx_q        <= '0;
      data_sr      <= '0;
      tag_sr       <= '0;
    end else begin
      start_q      <= ascon_startxSI;
      core_start_q <= go;
      if (load_shift && !full) count_q <= count_q + CNT_W'(1);
      if (go) decrypt_q <= decrypt;
      if ((state_q == LOAD) && start_edge && !full) load_err_q <= 1'b1;
      if (capture) begin
        data_sr <= core.core_data_i;
        tag_sr  <= core.core_tag_i;
        ready_q <= 1'b1;
        pre_q   <= '0;
        idx_q   <= '0;
      end else if (state_q == UNLOAD) begin
        if (shift_out) begin
          // Zero fill makes each stream idle low once its width is exhausted.
          data_sr <= data_sr >> 1;
          tag_sr  <= tag_sr >> 1;
          idx_q   <= idx_q + IDX_W'(1);
        end else begin
          pre_q <= pre_q + PRE_W'(1);
        end
      end
    end
  end

  ascon_sipo_lane #(.W(KEY_W), .CNT_W(CNT_W)) u_key (
    .clk(clk), .rst_n(rst_n), .clr(rst), .shift(load_shift), .count(count_q),
    .din(keyxSI), .q(key_lane)
  );
  ascon_sipo_lane #(.W(NONCE_W), .CNT_W(CNT_W)) u_nonce (
    .clk(clk), .rst_n(rst_n), .clr(rst), .shift(load_shift), .count(count_q),
    .din(noncexSI), .q(nonce_lane)
  );
  ascon_sipo_lane #(.W(AD_W), .CNT_W(CNT_W)) u_ad (
    .clk(clk), .rst_n(rst_n), .clr(rst), .shift(load_shift), .count(count_q),
    .din(associated_dataxSI), .q(ad_lane)
  );
  ascon_sipo_lane #(.W(DATA_W), .CNT_W(CNT_W)) u_data (
    .clk(clk), .rst_n(rst_n), .clr(rst), .shift(load_shift), .count(count_q),
    .din(input_dataxSI), .q(data_lane)
  );

  assign core.key_o        = key_lane;
  assign core.nonce_o      = nonce_lane;
  assign core.ad_o         = ad_lane;
  assign core.data_o       = data_lane;
  assign core.decrypt_o    = decrypt_q;
  assign core.core_start_o = core_start_q;

  assign output_dataxSO = (state_q == UNLOAD) & data_sr[0];
  assign tagxSO         = (state_q == UNLOAD) & tag_sr[0];
  assign ascon_readyxSO = ready_q;
  assign load_err_o     = load_err_q;

`ifdef ASCON_CYCLE_CNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (rst || go) begin
      cyc_q <= '0;
    end else if ((state_q == BUSY) && !core.core_done_i && (cyc_q != 16'hFFFF)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cycles_o = cyc_q;
`endif

endmodule

// File: tb/tb_ascon_serial_if.sv
// tb/tb_ascon_serial_if.sv - table-driven bench for ascon_serial_if with a latency-programmable core stub
module tb_ascon_serial_if;
  import ascon_if_pkg::*;

  typedef struct {
    logic [127:0] key;
    logic [127:0] nonce;
    logic [39:0]  ad;
    logic [103:0] din;
    logic         dec;
    logic [103:0] res;
    logic [127:0] tag;
    int           hold;
    int           lat;
  } vec_t;

  localparam logic [127:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
  localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
  localparam logic [39:0]  AD    = 40'h4153434f4e;
  localparam logic [103:0] PT    = 104'h6173636f6e2d756e6963617373;
  localparam logic [103:0] CT    = 104'h18490112f8d5867a830748390b;
  localparam logic [127:0] TAG   = 128'h4f9c2b1de0873a65c1d2e3f405162738;

  logic clk = 1'b0;
  logic rst_n, rst, key_si, nonce_si, ad_si, data_si, start_si, decrypt;
  logic data_so, tag_so, ready_so, load_err;
`ifdef ASCON_CYCLE_CNT_EN
  logic [15:0] cycles;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  vec_t vecs[3];

  ascon_serial_if_if bus ();

  ascon_serial_if dut (
    .clk(clk), .rst_n(rst_n), .rst(rst),
    .keyxSI(key_si), .noncexSI(nonce_si), .associated_dataxSI(ad_si),
    .input_dataxSI(data_si), .ascon_startxSI(start_si), .decrypt(decrypt),
    .output_dataxSO(data_so), .tagxSO(tag_so), .ascon_readyxSO(ready_so),
    .load_err_o(load_err),
`ifdef ASCON_CYCLE_CNT_EN
    .cycles_o(cycles),
`endif
    .core(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.core_start_o === 1'b1) n_start++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hard_reset();
    rst_n = 1'b0; rst = 1'b0; start_si = 1'b0; decrypt = 1'b0;
    key_si = 1'b0; nonce_si = 1'b0; ad_si = 1'b0; data_si = 1'b0;
    bus.core_done_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bits past a lane's width are driven high to show they are discarded.
  task automatic shift_bits(input vec_t v, input int first, input int last);
    for (int j = first; j < last; j++) begin
      key_si   = v.key[127-j];
      nonce_si = v.nonce[127-j];
      ad_si    = (j < 40)  ? v.ad[39-j]   : 1'b1;
      data_si  = (j < 104) ? v.din[103-j] : 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start(input int hold);
    start_si = 1'b1;
    repeat (hold) @(negedge clk);
    start_si = 1'b0;
  endtask

  task automatic run_core(input logic [103:0] res, input logic [127:0] tag, input int lat);
    int t = 0;
    while (t < 400 && bus.core_start_o !== 1'b1) begin
      @(negedge clk);
      t++;
    end
    chk("core_start_seen", 128'(bus.core_start_o), 128'(1));
    repeat (lat) @(negedge clk);
    bus.core_data_i = res;
    bus.core_tag_i  = tag;
    bus.core_done_i = 1'b1;
    @(negedge clk);
    bus.core_done_i = 1'b0;
    chk("ready_rise", 128'(ready_so), 128'(1));
  endtask

  task automatic collect(output logic [103:0] d, output logic [127:0] t, output int pad_bad);
    d = '0; t = '0; pad_bad = 0;
    for (int k = 0; k < DEF_PRE_CYC + 128; k++) begin
      if (k >= DEF_PRE_CYC) begin
        int i;
        i = k - DEF_PRE_CYC;
        if (i < 104) d[i] = data_so;
        else if (data_so !== 1'b0) pad_bad++;
        t[i] = tag_so;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [103:0] got_d;
    logic [127:0] got_t;
    int pad_bad, base;

    vecs[0] = '{KEY, NONCE, AD, PT, 1'b0, CT, TAG, 1, 30};
    vecs[1] = '{KEY, NONCE, AD, CT, 1'b1, PT, TAG, 6, 5};
    vecs[2] = '{{128{1'b1}}, {64{2'b10}}, 40'h8000000001, 104'h1, 1'b0,
                104'h80000000000000000000000001, {128{1'b1}}, 3, 1};

    hard_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_ready", 128'(ready_so), 128'(0));
    chk("reset_err", 128'(load_err), 128'(0));
    chk("reset_key", bus.key_o, 128'(0));
    chk("reset_start", 128'(bus.core_start_o), 128'(0));
    chk("reset_outs", 128'({data_so, tag_so}), 128'(0));

    for (int n = 0; n < 3; n++) begin
      hard_reset();
      base = n_start;
      decrypt = vecs[n].dec;
      shift_bits(vecs[n], 0, 128);
      fork
        pulse_start(vecs[n].hold);
        run_core(vecs[n].res, vecs[n].tag, vecs[n].lat);
      join
      chk("lane_key", bus.key_o, vecs[n].key);
      chk("lane_nonce", bus.nonce_o, vecs[n].nonce);
      chk("lane_ad", 128'(bus.ad_o), 128'(vecs[n].ad));
      chk("lane_data", 128'(bus.data_o), 128'(vecs[n].din));
      chk("decrypt_o", 128'(bus.decrypt_o), 128'(vecs[n].dec));
`ifdef ASCON_CYCLE_CNT_EN
      chk("cycles_o", 128'(cycles), 128'(vecs[n].lat));
`endif
      collect(got_d, got_t, pad_bad);
      chk("out_data", 128'(got_d), 128'(vecs[n].res));
      chk("out_tag", got_t, vecs[n].tag);
      chk("out_data_pad", 128'(pad_bad), 128'(0));
      chk("done_ready", 128'(ready_so), 128'(1));
      chk("done_outs", 128'({data_so, tag_so}), 128'(0));
      pulse_start(2);
      bus.core_done_i = 1'b1;
      @(negedge clk);
      bus.core_done_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_once", 128'(n_start - base), 128'(1));
      chk("done_hold", 128'({ready_so, data_so, tag_so}), 128'(3'b100));
      chk("no_err", 128'(load_err), 128'(0));
    end

    // Premature start, then completed load and restart.
    hard_reset();
    base = n_start;
    decrypt = 1'b0;
    shift_bits(vecs[0], 0, 50);
    start_si = 1'b1;
    @(negedge clk);
    chk("early_err", 128'(load_err), 128'(1));
    chk("early_no_start", 128'(n_start - base), 128'(0));
    start_si = 1'b0;
    shift_bits(vecs[0], 50, 128);
    fork
      pulse_start(1);
      run_core(CT, TAG, 30);
    join
    chk("err_sticky", 128'(load_err), 128'(1));
    chk("err_lane_key", bus.key_o, KEY);
    chk("err_lane_data", 128'(bus.data_o), 128'(PT));
    chk("err_start_once", 128'(n_start - base), 128'(1));
    collect(got_d, got_t, pad_bad);
    chk("err_out_data", 128'(got_d), 128'(CT));

    // Stray done during load, then async reset in the middle of unload.
    hard_reset();
    base = n_start;
    shift_bits(vecs[0], 0, 60);
    bus.core_done_i = 1'b1;
    shift_bits(vecs[0], 60, 61);
    bus.core_done_i = 1'b0;
    shift_bits(vecs[0], 61, 128);
    chk("stray_done_ready", 128'(ready_so), 128'(0));
    fork
      pulse_start(6);
      run_core(CT, TAG, 30);
    join
    chk("stray_lane_nonce", bus.nonce_o, NONCE);
    chk("stray_start_once", 128'(n_start - base), 128'(1));
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready", 128'(ready_so), 128'(0));
    chk("async_outs", 128'({data_so, tag_so}), 128'(0));
    chk("async_state", 128'(dut.state_q), 128'(LOAD));

    // Soft clear mid-unload takes effect at the next edge.
    hard_reset();
    shift_bits(vecs[0], 0, 128);
    fork
      pulse_start(1);
      run_core(CT, TAG, 30);
    join
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("soft_before_edge", 128'(ready_so), 128'(1));
    @(negedge clk);
    chk("soft_ready", 128'(ready_so), 128'(0));
    chk("soft_outs", 128'({data_so, tag_so}), 128'(0));
    chk("soft_key", bus.key_o, 128'(0));
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_serial_if.md
Name: ascon_serial_if

Overview:
- Core-side end of the bit-serial ASCON pad protocol.
- Deserializes key, nonce, associated data and input data shifted in MSB-first from the mprj pads and presents them in parallel to the ASCON core.
- Issues a one-cycle core start, then serializes the core's output data and tag back to the pads LSB-first, with a ready flag.
- Sits between the pad wrapper and the ascon core inside the user project.

Parameters:
KEY_W, 128, key lane width
NONCE_W, 128, nonce lane width
AD_W, 40, associated-data lane width
DATA_W, 104, plaintext/ciphertext lane width
TAG_W, 128, tag width
PRE_CYC, 2, cycles ready is high before the output bit index advances

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rst  in  1  pad soft clear, synchronous, active-high
keyxSI  in  1  key serial in, MSB first
noncexSI  in  1  nonce serial in, MSB first
associated_dataxSI  in  1  AD serial in, MSB first
input_dataxSI  in  1  PT/CT serial in, MSB first
ascon_startxSI  in  1  start level from pad
decrypt  in  1  1=decrypt, 0=encrypt
output_dataxSO  out  1  PT/CT serial out, LSB first
tagxSO  out  1  tag serial out, LSB first
ascon_readyxSO  out  1  result available
key_o / nonce_o / ad_o / data_o  out  KEY_W/NONCE_W/AD_W/DATA_W  parallel lanes to core
decrypt_o  out  1  mode latched at start
core_start_o  out  1  one-cycle start pulse to core
core_done_i  in  1  core finished, single-cycle pulse
core_data_i  in  DATA_W  core result data
core_tag_i  in  TAG_W  core result tag
load_err_o  out  1  sticky: start seen before lanes full

Behaviour:
- Reset: rst_n low or rst high forces LOAD, all lanes and counters 0, all outputs 0.
- MAX_W = max(KEY_W, NONCE_W, AD_W, DATA_W).
- Bit counter: width clog2(MAX_W+1); increments every clock in LOAD while ascon_startxSI is low; saturates at MAX_W.
- Lane shift: lane L shifts left, new bit into LSB, only while count < W_L, so later bits are ignored. After the load, bit 0 of the serial stream sits at the lane MSB.
- Start detection: registered rising edge of ascon_startxSI.
- States:
  - LOAD: shift lanes as above. On start edge: if count == MAX_W, latch decrypt into decrypt_o, pulse core_start_o for 1 cycle, go BUSY. Otherwise set load_err_o, stay in LOAD, do not clear lanes.
  - BUSY: lanes held stable. On core_done_i, capture core_data_i/core_tag_i into output shift regs, set ascon_readyxSO the next cycle, go UNLOAD.
  - UNLOAD: with k = cycles since ready rose (k=0 is ready's first cycle), output bit index = max(0, k-PRE_CYC). output_dataxSO drives data bit index while index < DATA_W, else 0. tagxSO drives tag bit index while index < TAG_W, else 0. When index reaches max(DATA_W,TAG_W), go DONE.
  - DONE: ascon_readyxSO stays 1, serial outputs 0. Start edges are ignored; only rst/rst_n return to LOAD.
- Start level held for several cycles produces exactly one core_start_o.
- core_done_i outside BUSY is ignored.
- Reset mid-UNLOAD: outputs drop to 0 in the same cycle (async) or the next edge (soft clear).

Optional Feature:
- Macro ASCON_CYCLE_CNT_EN.
- Defined: adds output cycles_o[15:0]. Cleared on core_start_o, increments each BUSY cycle, saturates at 16'hFFFF, frozen at core_done_i.
- Undefined: port and counter absent.

Decomposition:
- Package ascon_if_pkg: width constants, MAX_W function, state enum {LOAD, BUSY, UNLOAD, DONE}, PRE_CYC default.
- Sub-module ascon_sipo_lane (param W): shift-in register with enable = count < W, instantiated four times.

Test Plan:
- Encrypt load: key 6d4f8bbf60ec05a07b201d4e5b2119ac, nonce 05885e606e1271b8d47a74c7b297a318, AD 4153434f4e, PT 6173636f6e2d756e6963617373, 128 cycles then start -> lanes equal those values; single core_start_o; decrypt_o=0.
- Core stub returns data 18490112f8d5867a830748390b plus a fixed tag after 30 cycles -> ready rises; bits sampled LSB-first from k=PRE_CYC reassemble both words exactly.
- Decrypt with CT 18490112f8d5867a830748390b -> data_o = CT, decrypt_o=1, output stream returns stub PT 6173636f6e2d756e6963617373.
- Start after only 50 bits -> load_err_o=1, no core_start_o. Complete 128 bits, restart -> normal run.
- Start held high 6 cycles; core_done_i pulsed in LOAD -> one core_start_o; stray done ignored.
- rst_n asserted mid-UNLOAD -> ready/outputs 0 immediately, state LOAD. With ASCON_CYCLE_CNT_EN, a 30-cycle stub gives cycles_o=30.
